// File: rtl/reg_bank_pkg.sv
// Shared defaults and helpers for the two-write-port register bank.
// PC writes and PC bypass both go through pc_align, so the two paths cannot disagree.
package reg_bank_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_NRD       = 2;
  localparam int DEF_PC_IDX    = 15;
  localparam int DEF_PC_OFFSET = 8;

  // Wide enough for any supported DATA_W; callers cast the result back down.
  localparam int ALIGN_W = 64;

  function automatic logic [ALIGN_W-1:0] pc_align(input logic [ALIGN_W-1:0] data);
    return {data[ALIGN_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// One combinational read port: array mux, write-to-read bypass (W1 over W0),
// PC read offset and scoreboard busy lookup with same-cycle load retire.
module reg_bank_rdport
  import reg_bank_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int PC_IDX    = DEF_PC_IDX,
  parameter int PC_OFFSET = DEF_PC_OFFSET,
  parameter int BYPASS    = 1
) (
  input  logic                           clr,
  input  logic                           we0,
  input  logic [ADDR_W-1:0]              wa0,
  input  logic [DATA_W-1:0]              w0Data,
  input  logic                           we1,
  input  logic [ADDR_W-1:0]              wa1,
  input  logic [DATA_W-1:0]              w1Data,
  input  logic [(2**ADDR_W)*DATA_W-1:0]  regsFlat,
  input  logic [(2**ADDR_W)-1:0]         busyVec,
  input  logic [ADDR_W-1:0]              ra,
  output logic [DATA_W-1:0]              rdData,
  output logic                           rdBusy
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              hit0, hit1, fwdOk, isPc;
  logic [DATA_W-1:0] value;

  for (genvar gi = 0; gi < NREG; gi++) begin : gUnpack
    assign regs[gi] = regsFlat[gi*DATA_W +: DATA_W];
  end

  assign hit0  = we0 && (wa0 == ra);
  assign hit1  = we1 && (wa1 == ra);
  assign fwdOk = (BYPASS != 0) && !clr;
  assign isPc  = (ra == ADDR_W'(PC_IDX));

  // Write data arrives already PC-aligned, so forwarded PC values need no extra masking.
  always_comb begin
    value = regs[ra];
    if (fwdOk && hit1)
      value = w1Data;
    else if (fwdOk && hit0)
      value = w0Data;
    rdData = isPc ? value + DATA_W'(PC_OFFSET) : value;
  end

  assign rdBusy = busyVec[ra] && !((BYPASS != 0) && hit1);

endmodule

// File: rtl/reg_bank_2w.sv
// Register bank with ALU (W0) and load (W1) write ports, NRD bypassed read ports
// and a per-register load scoreboard used by decode for stall detection.
module reg_bank_2w
  import reg_bank_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NRD       = DEF_NRD,
  parameter int PC_IDX    = DEF_PC_IDX,
  parameter int PC_OFFSET = DEF_PC_OFFSET,
  parameter int BYPASS    = 1
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    we0,
  input  logic [ADDR_W-1:0]       wa0,
  input  logic [DATA_W-1:0]       wd0,
  input  logic                    we1,
  input  logic [ADDR_W-1:0]       wa1,
  input  logic [DATA_W-1:0]       wd1,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*DATA_W-1:0]   rd,
  input  logic                    mark_vld,
  input  logic [ADDR_W-1:0]       mark_addr,
  output logic [(2**ADDR_W)-1:0]  busy,
  output logic [NRD-1:0]          rd_busy,
  output logic                    sb_err
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0]      regArray [NREG];
  logic [NREG*DATA_W-1:0] regsFlat;
  logic [NREG-1:0]        busyReg, busyNext, setMask, clrMask;
  logic                   sbErrReg, sbErrNext;
  logic [DATA_W-1:0]      w0Data, w1Data;

  assign w0Data = (wa0 == ADDR_W'(PC_IDX)) ? DATA_W'(pc_align(ALIGN_W'(wd0))) : wd0;
  assign w1Data = (wa1 == ADDR_W'(PC_IDX)) ? DATA_W'(pc_align(ALIGN_W'(wd1))) : wd1;

  // A mark and a retire on the same register leave it busy: the new load is still pending.
  always_comb begin
    setMask   = mark_vld ? (NREG'(1) << mark_addr) : '0;
    clrMask   = we1 ? (NREG'(1) << wa1) : '0;
    busyNext  = (busyReg & ~clrMask) | setMask;
    sbErrNext = sbErrReg | (mark_vld & busyReg[mark_addr] & ~clrMask[mark_addr]);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int i = 0; i < NREG; i++)
        regArray[i] <= '0;
      busyReg  <= '0;
      sbErrReg <= 1'b0;
    end else begin
      if (we0)
        regArray[wa0] <= w0Data;
      // Issued after W0 so the load port wins an address collision.
      if (we1)
        regArray[wa1] <= w1Data;
      busyReg  <= busyNext;
      sbErrReg <= sbErrNext;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : gFlat
    assign regsFlat[gi*DATA_W +: DATA_W] = regArray[gi];
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : gRd
    reg_bank_rdport #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .PC_IDX    (PC_IDX),
      .PC_OFFSET (PC_OFFSET),
      .BYPASS    (BYPASS)
    ) uRdPort (
      .clr      (CLR),
      .we0      (we0),
      .wa0      (wa0),
      .w0Data   (w0Data),
      .we1      (we1),
      .wa1      (wa1),
      .w1Data   (w1Data),
      .regsFlat (regsFlat),
      .busyVec  (busyReg),
      .ra       (ra[gi*ADDR_W +: ADDR_W]),
      .rdData   (rd[gi*DATA_W +: DATA_W]),
      .rdBusy   (rd_busy[gi])
    );
  end

  assign busy   = busyReg;
  assign sb_err = sbErrReg;

endmodule

// File: tb/tb_reg_bank_2w.sv
// Random and directed stimulus for reg_bank_2w, checked every cycle against an
// array-based model of the register file and load scoreboard.
module tb_reg_bank_2w;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NRD  = 2;
  localparam int NREG = 16;
  localparam int PCI  = 15;
  localparam int PCO  = 8;

  logic              CLK = 1'b0;
  logic              CLR = 1'b1;
  logic              we0 = 1'b0, we1 = 1'b0, mark_vld = 1'b0;
  logic [AW-1:0]     wa0 = '0, wa1 = '0, mark_addr = '0;
  logic [DW-1:0]     wd0 = '0, wd1 = '0;
  logic [NRD*AW-1:0] ra = '0;
  logic [NRD*DW-1:0] rd;
  logic [NREG-1:0]   busy;
  logic [NRD-1:0]    rd_busy;
  logic              sb_err;

  int checks = 0;
  int errors = 0;
  bit chkEn  = 1'b0;

  logic [31:0] mRegs [NREG];
  bit          mBusy [NREG];
  bit          mSbErr;

  reg_bank_2w #(
    .DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .PC_IDX(PCI), .PC_OFFSET(PCO), .BYPASS(1)
  ) dut (
    .CLK(CLK), .CLR(CLR),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd),
    .mark_vld(mark_vld), .mark_addr(mark_addr),
    .busy(busy), .rd_busy(rd_busy), .sb_err(sb_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] alignFor(int a, logic [31:0] d);
    logic [31:0] r;
    r = d;
    if (a == PCI) r[1:0] = 2'b00;
    return r;
  endfunction

  function automatic logic [31:0] expRd(int k);
    int a;
    logic [31:0] v;
    a = int'(ra[k*AW +: AW]);
    v = mRegs[a];
    if (!CLR && we1 && int'(wa1) == a)      v = alignFor(a, wd1);
    else if (!CLR && we0 && int'(wa0) == a) v = alignFor(a, wd0);
    if (a == PCI) v = v + 32'(PCO);
    return v;
  endfunction

  function automatic logic expRdBusy(int k);
    int a;
    a = int'(ra[k*AW +: AW]);
    return mBusy[a] && !(we1 && int'(wa1) == a);
  endfunction

  function automatic logic [31:0] expBusyVec();
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < NREG; r++) v[r] = mBusy[r];
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge.
  always @(posedge CLK) begin
    if (CLR) begin
      for (int r = 0; r < NREG; r++) begin
        mRegs[r] <= '0;
        mBusy[r] <= 1'b0;
      end
      mSbErr <= 1'b0;
    end else begin
      if (mark_vld && mBusy[mark_addr] && !(we1 && wa1 == mark_addr))
        mSbErr <= 1'b1;
      for (int r = 0; r < NREG; r++) begin
        if (mark_vld && int'(mark_addr) == r)  mBusy[r] <= 1'b1;
        else if (we1 && int'(wa1) == r)        mBusy[r] <= 1'b0;
      end
      if (we0) mRegs[wa0] <= alignFor(int'(wa0), wd0);
      if (we1) mRegs[wa1] <= alignFor(int'(wa1), wd1);
    end
  end

  // Compare process: inputs change on the falling edge, outputs checked 1 time unit later.
  always @(negedge CLK) begin
    #1;
    if (chkEn) begin
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("rd%0d", k), rd[k*DW +: DW], expRd(k));
        check($sformatf("rd_busy%0d", k), 32'(rd_busy[k]), 32'(expRdBusy(k)));
      end
      check("busy", 32'(busy), expBusyVec());
      check("sb_err", 32'(sb_err), 32'(mSbErr));
    end
  end

  task automatic idle();
    CLR = 1'b0; we0 = 1'b0; we1 = 1'b0; mark_vld = 1'b0;
  endtask

  task automatic setRa(int r1, int r0);
    ra = {4'(r1), 4'(r0)};
  endtask

  initial begin
    @(posedge CLK);
    chkEn = 1'b1;

    // Reset state
    @(negedge CLK); idle(); setRa(15, 0); #2;
    $display("txn reset: rd0=%h rd1=%h busy=%h sb_err=%b", rd[31:0], rd[63:32], busy, sb_err);
    check("reset_rd0", rd[31:0], 32'h0);
    check("reset_pc", rd[63:32], 32'h8);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_sberr", 32'(sb_err), 32'h0);

    // W0 bypass then stored
    @(negedge CLK); idle(); we0 = 1; wa0 = 3; wd0 = 32'h1234; setRa(15, 3); #2;
    $display("txn w0 r3 bypass: rd0=%h", rd[31:0]);
    check("bypass_w0", rd[31:0], 32'h1234);
    @(negedge CLK); idle(); #2;
    $display("txn read r3: rd0=%h", rd[31:0]);
    check("stored_w0", rd[31:0], 32'h1234);

    // W1 over W0 on collision
    @(negedge CLK); idle(); we0 = 1; wa0 = 5; wd0 = 32'hAAAA; we1 = 1; wa1 = 5; wd1 = 32'h5555; setRa(15, 5); #2;
    $display("txn w0+w1 r5: rd0=%h", rd[31:0]);
    check("collide_fwd", rd[31:0], 32'h5555);
    @(negedge CLK); idle(); #2;
    check("collide_store", rd[31:0], 32'h5555);

    // PC alignment and offset wrap
    @(negedge CLK); idle(); we0 = 1; wa0 = 15; wd0 = 32'h103; #2;
    @(negedge CLK); idle(); #2;
    $display("txn read pc: rd1=%h", rd[63:32]);
    check("pc_align", rd[63:32], 32'h108);
    @(negedge CLK); idle(); we0 = 1; wa0 = 15; wd0 = 32'hFFFF_FFFC; #2;
    @(negedge CLK); idle(); #2;
    $display("txn read pc wrap: rd1=%h", rd[63:32]);
    check("pc_wrap", rd[63:32], 32'h4);

    // Scoreboard mark / retire
    @(negedge CLK); idle(); mark_vld = 1; mark_addr = 7; setRa(15, 7); #2;
    @(negedge CLK); idle(); #2;
    $display("txn mark r7: busy=%h rd_busy=%b", busy, rd_busy);
    check("mark_busy7", 32'(busy[7]), 32'h1);
    check("mark_rdbusy", 32'(rd_busy[0]), 32'h1);
    @(negedge CLK); idle(); we1 = 1; wa1 = 7; wd1 = 32'h77; #2;
    $display("txn retire r7: rd0=%h rd_busy=%b", rd[31:0], rd_busy);
    check("retire_rdbusy", 32'(rd_busy[0]), 32'h0);
    check("retire_fwd", rd[31:0], 32'h77);
    @(negedge CLK); idle(); #2;
    check("retire_busy7", 32'(busy[7]), 32'h0);
    @(negedge CLK); idle(); mark_vld = 1; mark_addr = 7; #2;
    @(negedge CLK); idle(); mark_vld = 1; mark_addr = 7; we1 = 1; wa1 = 7; wd1 = 32'h99; #2;
    @(negedge CLK); idle(); #2;
    $display("txn mark+retire r7: busy=%h sb_err=%b", busy, sb_err);
    check("remark_busy7", 32'(busy[7]), 32'h1);
    check("remark_sberr", 32'(sb_err), 32'h0);

    // Double mark -> sticky sb_err, cleared with busy by CLR
    @(negedge CLK); idle(); mark_vld = 1; mark_addr = 2; #2;
    @(negedge CLK); idle(); mark_vld = 1; mark_addr = 2; #2;
    @(negedge CLK); idle(); #2;
    check("dbl_sberr", 32'(sb_err), 32'h1);
    @(negedge CLK); idle(); #2;
    $display("txn double mark r2: sb_err=%b busy=%h", sb_err, busy);
    check("sticky_sberr", 32'(sb_err), 32'h1);
    @(negedge CLK); idle(); CLR = 1; #2;
    @(negedge CLK); idle(); setRa(15, 5); #2;
    $display("txn clr: busy=%h sb_err=%b rd0=%h", busy, sb_err, rd[31:0]);
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_sberr", 32'(sb_err), 32'h0);
    check("clr_rd0", rd[31:0], 32'h0);

    // Randomized traffic, addresses narrowed at times to force collisions
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      CLR       = ($urandom_range(0, 39) == 0);
      we0       = 1'($urandom_range(0, 1));
      we1       = ($urandom_range(0, 2) == 0);
      mark_vld  = ($urandom_range(0, 3) == 0);
      wa0       = 4'($urandom_range(0, 15));
      wa1       = ($urandom_range(0, 3) == 0) ? wa0 : 4'($urandom_range(0, 15));
      mark_addr = ($urandom_range(0, 3) == 0) ? wa1 : 4'($urandom_range(0, 15));
      wd0       = $urandom;
      wd1       = $urandom;
      ra        = 8'($urandom);
      if ($urandom_range(0, 4) == 0) ra[3:0] = wa1;
      if ($urandom_range(0, 4) == 0) ra[7:4] = 4'(PCI);
      #2;
      $display("txn %0d clr=%b w0=%b:%h=%h w1=%b:%h=%h mk=%b:%h ra=%h rd=%h rb=%b busy=%h err=%b",
               i, CLR, we0, wa0, wd0, we1, wa1, wd1, mark_vld, mark_addr, ra, rd, rd_busy, busy, sb_err);
    end

    @(negedge CLK); idle(); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
